// File: rtl/multicycle_sequencer_pkg.sv
// Shared encodings for the multi-cycle processor sequencer: states, opcodes
// and the instruction classes that select each instruction's cycle path.
package mc_pkg;

   localparam int unsigned PC_W    = 4;
   localparam int unsigned INSTR_W = 32;
   localparam int unsigned OP_W    = 6;

   typedef enum logic [2:0] {
      S_FETCH     = 3'd0,
      S_DECODE    = 3'd1,
      S_EXECUTE   = 3'd2,
      S_MEM       = 3'd3,
      S_WRITEBACK = 3'd4,
      S_HALT      = 3'd5,
      S_IDLE      = 3'd6
   } state_e;

   localparam logic [OP_W-1:0] OP_RTYPE = 6'd0;
   localparam logic [OP_W-1:0] OP_ADDIU = 6'd9;
   localparam logic [OP_W-1:0] OP_LW    = 6'd35;
   localparam logic [OP_W-1:0] OP_SW    = 6'd43;
   localparam logic [OP_W-1:0] OP_BEQ   = 6'd4;
   localparam logic [OP_W-1:0] OP_BNE   = 6'd5;
   localparam logic [OP_W-1:0] OP_JAL   = 6'd3;
   localparam logic [OP_W-1:0] FN_JR    = 6'd8;

   typedef enum logic [2:0] {
      CL_ALU = 3'd0,
      CL_LW  = 3'd1,
      CL_SW  = 3'd2,
      CL_BEQ = 3'd3,
      CL_BNE = 3'd4,
      CL_JAL = 3'd5,
      CL_JR  = 3'd6,
      CL_ILL = 3'd7
   } cls_e;

   // Map opcode/funct to the class that selects the cycle path and next-PC rule.
   function automatic cls_e decode_class(input logic [OP_W-1:0] op, input logic [OP_W-1:0] fn);
      cls_e cls;
      cls = CL_ILL;
      case (op)
         OP_RTYPE: cls = (fn == FN_JR) ? CL_JR : CL_ALU;
         OP_ADDIU: cls = CL_ALU;
         OP_LW:    cls = CL_LW;
         OP_SW:    cls = CL_SW;
         OP_BEQ:   cls = CL_BEQ;
         OP_BNE:   cls = CL_BNE;
         OP_JAL:   cls = CL_JAL;
         default:  cls = CL_ILL;
      endcase
      return cls;
   endfunction

endpackage

// File: rtl/multicycle_sequencer_if.sv
// Sequencer <-> datapath/instruction-memory bundle; the sequencer is the slave
// side, the surrounding datapath (or bench) the master side.
interface multicycle_sequencer_if #(
   parameter int unsigned CNT_W = 8
);
   logic             start;
   logic [31:0]      instruction;
   logic             alu_zero;
   logic [3:0]       jr_target;
   logic [2:0]       state;
   logic [3:0]       pc;
   logic             link_we;
   logic [3:0]       link_pc;
   logic             done;
   logic             illegal;
   logic [CNT_W-1:0] retired;

   modport master (
      output start, instruction, alu_zero, jr_target,
      input  state, pc, link_we, link_pc, done, illegal, retired
   );

   modport slave (
      input  start, instruction, alu_zero, jr_target,
      output state, pc, link_we, link_pc, done, illegal, retired
   );
endinterface

// File: rtl/multicycle_sequencer_next_pc_calc.sv
// Next-PC selection for sequential, branch, jal and jr flow; all arithmetic
// wraps modulo 16.
module next_pc_calc
   import mc_pkg::*;
(
   input  logic [PC_W-1:0] pc,
   input  cls_e            cls,
   input  logic [3:0]      imm,
   input  logic [3:0]      target,
   input  logic            alu_zero,
   input  logic [3:0]      jr_target,
   output logic [PC_W-1:0] next_pc
);

   logic [PC_W-1:0] pc_inc;

   assign pc_inc = pc + PC_W'(1);

   // Branch offset is the sign-extended immediate truncated to the PC width.
   always_comb begin
      next_pc = pc_inc;
      case (cls)
         CL_BEQ:  next_pc = alu_zero  ? pc_inc + imm : pc_inc;
         CL_BNE:  next_pc = !alu_zero ? pc_inc + imm : pc_inc;
         CL_JAL:  next_pc = target;
         CL_JR:   next_pc = jr_target;
         default: next_pc = pc_inc;
      endcase
   end

endmodule

// File: rtl/multicycle_sequencer.sv
// Control sequencer of the 14-word multi-cycle processor: walks each
// instruction through its class-dependent cycle path and commits the next PC.
module multicycle_sequencer
   import mc_pkg::*;
#(
   parameter int unsigned START_PC = 12,
   parameter int unsigned PROG_LEN = 14,
   parameter int unsigned CNT_W    = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   multicycle_sequencer_if.slave bus
);

   state_e            state_q, state_nxt;
   logic [PC_W-1:0]   pc_q, pc_nxt;
   logic [CNT_W-1:0]  retired_q, retired_nxt;
   cls_e              cls_q, cls_nxt;
   logic              link_we_q, link_we_nxt;
   logic [PC_W-1:0]   link_pc_q, link_pc_nxt;
   logic              done_q, done_nxt;
   logic              illegal_q, illegal_nxt;

   cls_e              cls_dec_c;
   logic [PC_W-1:0]   next_pc_c;
   logic              halt_c;
   logic              commit_c;
   logic              restart_c;
   logic              unused_instr_bits;

   assign cls_dec_c         = decode_class(bus.instruction[31:26], bus.instruction[5:0]);
   assign unused_instr_bits = ^bus.instruction[25:6];

   next_pc_calc u_next_pc (
      .pc        (pc_q),
      .cls       (cls_q),
      .imm       (bus.instruction[3:0]),
      .target    (bus.instruction[3:0]),
      .alu_zero  (bus.alu_zero),
      .jr_target (bus.jr_target),
      .next_pc   (next_pc_c)
   );

   assign halt_c    = 32'(next_pc_c) >= PROG_LEN;
   assign restart_c = bus.start && (state_q == S_IDLE || state_q == S_HALT);

   // Final edge of an instruction: branches/jumps in EXECUTE, sw in MEM, rest in WRITEBACK.
   always_comb begin
      commit_c = 1'b0;
      case (state_q)
         S_EXECUTE:   commit_c = (cls_q == CL_BEQ) || (cls_q == CL_BNE) ||
                                 (cls_q == CL_JAL) || (cls_q == CL_JR);
         S_MEM:       commit_c = (cls_q == CL_SW);
         S_WRITEBACK: commit_c = 1'b1;
         default:     commit_c = 1'b0;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= S_IDLE;
         pc_q      <= PC_W'(START_PC);
         retired_q <= '0;
         cls_q     <= CL_ALU;
         link_we_q <= 1'b0;
         link_pc_q <= '0;
         done_q    <= 1'b0;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_nxt;
         pc_q      <= pc_nxt;
         retired_q <= retired_nxt;
         cls_q     <= cls_nxt;
         link_we_q <= link_we_nxt;
         link_pc_q <= link_pc_nxt;
         done_q    <= done_nxt;
         illegal_q <= illegal_nxt;
      end
   end

   // Next-state logic.
   always_comb begin
      state_nxt = state_q;
      case (state_q)
         S_IDLE, S_HALT: if (restart_c) state_nxt = S_FETCH;
         S_FETCH:        state_nxt = S_DECODE;
         S_DECODE:       state_nxt = (cls_dec_c == CL_ILL) ? S_HALT : S_EXECUTE;
         S_EXECUTE: begin
            if (commit_c)                                 state_nxt = halt_c ? S_HALT : S_FETCH;
            else if (cls_q == CL_LW || cls_q == CL_SW)    state_nxt = S_MEM;
            else                                          state_nxt = S_WRITEBACK;
         end
         S_MEM: begin
            if (commit_c) state_nxt = halt_c ? S_HALT : S_FETCH;
            else          state_nxt = S_WRITEBACK;
         end
         S_WRITEBACK:    state_nxt = halt_c ? S_HALT : S_FETCH;
         default:        state_nxt = S_IDLE;
      endcase
   end

   // Registered-output next values; link_we is a single EXECUTE-cycle pulse.
   always_comb begin
      pc_nxt      = pc_q;
      retired_nxt = retired_q;
      cls_nxt     = cls_q;
      link_we_nxt = 1'b0;
      link_pc_nxt = '0;
      done_nxt    = done_q;
      illegal_nxt = illegal_q;
      if (restart_c) begin
         pc_nxt      = PC_W'(START_PC);
         retired_nxt = '0;
         done_nxt    = 1'b0;
         illegal_nxt = 1'b0;
      end
      if (state_q == S_DECODE) begin
         cls_nxt = cls_dec_c;
         if (cls_dec_c == CL_ILL) begin
            illegal_nxt = 1'b1;
         end else if (cls_dec_c == CL_JAL) begin
            link_we_nxt = 1'b1;
            link_pc_nxt = pc_q + PC_W'(1);
         end
      end
      if (commit_c) begin
         pc_nxt      = next_pc_c;
         retired_nxt = (retired_q == '1) ? retired_q : retired_q + CNT_W'(1);
         if (halt_c) done_nxt = 1'b1;
      end
   end

   assign bus.state   = state_q;
   assign bus.pc      = pc_q;
   assign bus.retired = retired_q;
   assign bus.link_we = link_we_q;
   assign bus.link_pc = link_pc_q;
   assign bus.done    = done_q;
   assign bus.illegal = illegal_q;

endmodule
